// File: rtl/tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo_pkg
// Description : Shared constants and width helpers for the single-clock TX
//               FIFO (tx_fifo_sc) and its storage RAM (tx_fifo_ram).
//               Widths are exposed as functions of ADDR_WIDTH because the
//               importing modules are parameterised. The importers build
//               their ptr_t / lvl_t typedefs from these helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_fifo_pkg;

    // Reset values of the status flags and of the read-valid register.
    localparam logic c_FLAG_RST   = 1'b0;
    localparam logic c_RVALID_RST = 1'b0;

    // Number of words the FIFO holds: 2**aw.
    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // Width of a RAM pointer. Pointers wrap modulo the depth.
    function automatic int ptr_width(input int aw);
        return aw;
    endfunction

    // Width of a level counter. It must represent 0..DEPTH inclusive.
    function automatic int lvl_width(input int aw);
        return aw + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo_ram
// Description : Simple dual-port RAM with a synchronous, enabled read port.
//               The read-data register doubles as the FIFO's FWFT output
//               (prefetch) register. It is reset to zero so that the head
//               word reads as 0 after reset. The array itself is not reset.
// Ports       : i_clk, i_rst     clock, async active-high reset (rd reg only)
//               i_wr_en/addr/data write port
//               i_rd_en/addr      read request, data valid after the edge
//               o_rd_data         registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo_ram
    import tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/tx_fifo_sc.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo_sc
// Description : Single-clock transmit FIFO with a first-word-fall-through
//               read port. It has programmable almost-full/almost-empty
//               thresholds, a fill-level output and sticky overflow/underflow
//               flags. Capacity is DEPTH words, including the output register.
//               Optional packet commit/drop mode is enabled by the macro
//               TX_FIFO_PKT_MODE_EN.
// Ports       : i_clk, i_rst (async, active-high)
//               push side : i_push, i_wdata, i_wlast, i_wdrop, o_full
//               pop side  : o_rvalid, o_rdata, i_pop
//               status    : o_level, o_afull, o_aempty, o_ovf, o_udf
//               control   : i_afull_thr, i_aempty_thr, i_clr_err
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo_sc
    import tx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_wlast,
    input  logic                  i_wdrop,
    output logic                  o_full,
    output logic                  o_rvalid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic                  i_pop,
    output logic [ADDR_WIDTH:0]   o_level,
    input  logic [ADDR_WIDTH:0]   i_afull_thr,
    input  logic [ADDR_WIDTH:0]   i_aempty_thr,
    output logic                  o_afull,
    output logic                  o_aempty,
    input  logic                  i_clr_err,
    output logic                  o_ovf,
    output logic                  o_udf
);

    localparam int c_PW    = ptr_width(ADDR_WIDTH);
    localparam int c_LW    = lvl_width(ADDR_WIDTH);
    localparam int c_DEPTH = fifo_depth(ADDR_WIDTH);

    typedef logic [c_PW-1:0] ptr_t;
    typedef logic [c_LW-1:0] lvl_t;

    localparam lvl_t c_DEPTH_L = lvl_t'(c_DEPTH);

    ptr_t r_wr_ptr;
    ptr_t r_rd_ptr;
    lvl_t r_level;   // readable words: RAM (committed) plus output register
    lvl_t r_total;   // every word held, including an uncommitted packet
    logic r_full;
    logic r_rvalid;
    logic r_ovf;
    logic r_udf;

    logic w_push_acc;
    logic w_pop_acc;
    logic w_ovf_evt;
    logic w_udf_evt;
    logic w_rd_en;
    lvl_t w_readable_add;
    lvl_t w_discard;
    ptr_t w_wr_ptr_nxt;
    lvl_t w_total_nxt;
    lvl_t w_level_nxt;

    assign w_pop_acc = i_pop & r_rvalid;
    assign w_udf_evt = i_pop & ~r_rvalid;
    assign w_ovf_evt = i_push & r_full;

    // Refill the output register whenever it is empty or being drained and
    // the RAM still has a readable word (level counts the output slot).
    assign w_rd_en = (r_level > lvl_t'(r_rvalid)) & (~r_rvalid | w_pop_acc);

`ifdef TX_FIFO_PKT_MODE_EN
    ptr_t r_cmt_ptr;
    lvl_t r_uncmt;
    logic w_drop;
    logic w_commit;

    // A push that hits full while a packet is pending discards that packet.
    assign w_drop     = i_wdrop | (w_ovf_evt & (r_uncmt != '0));
    assign w_push_acc = i_push & ~r_full & ~i_wdrop;
    assign w_commit   = w_push_acc & i_wlast;

    always_comb begin
        w_readable_add = '0;
        w_discard      = '0;
        w_wr_ptr_nxt   = r_wr_ptr;
        if (w_commit) begin
            w_readable_add = r_uncmt + lvl_t'(1);
        end
        if (w_drop) begin
            w_discard    = r_uncmt;
            w_wr_ptr_nxt = r_cmt_ptr;
        end else if (w_push_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmt_ptr <= '0;
            r_uncmt   <= '0;
        end else if (w_drop) begin
            r_uncmt   <= '0;
        end else if (w_commit) begin
            r_cmt_ptr <= r_wr_ptr + ptr_t'(1);
            r_uncmt   <= '0;
        end else if (w_push_acc) begin
            r_uncmt   <= r_uncmt + lvl_t'(1);
        end
    end
`else
    logic w_unused_pkt;

    assign w_unused_pkt   = i_wlast ^ i_wdrop;
    assign w_push_acc     = i_push & ~r_full;
    assign w_readable_add = lvl_t'(w_push_acc);
    assign w_discard      = '0;
    assign w_wr_ptr_nxt   = w_push_acc ? (r_wr_ptr + ptr_t'(1)) : r_wr_ptr;
`endif

    assign w_total_nxt = r_total + lvl_t'(w_push_acc) - lvl_t'(w_pop_acc) - w_discard;
    assign w_level_nxt = r_level + w_readable_add - lvl_t'(w_pop_acc);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_total  <= '0;
            r_full   <= c_FLAG_RST;
            r_rvalid <= c_RVALID_RST;
            r_ovf    <= c_FLAG_RST;
            r_udf    <= c_FLAG_RST;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            r_level  <= w_level_nxt;
            r_total  <= w_total_nxt;
            r_full   <= (w_total_nxt == c_DEPTH_L);
            r_rvalid <= w_rd_en | (r_rvalid & ~w_pop_acc);
            // A new error event in the same cycle as a clear keeps the flag set.
            r_ovf    <= w_ovf_evt | (r_ovf & ~i_clr_err);
            r_udf    <= w_udf_evt | (r_udf & ~i_clr_err);
        end
    end

    tx_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_push_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_wdata),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (o_rdata)
    );

    assign o_full   = r_full;
    assign o_rvalid = r_rvalid;
    assign o_level  = r_level;
    assign o_afull  = (r_total >= i_afull_thr);
    assign o_aempty = (r_level <= i_aempty_thr);
    assign o_ovf    = r_ovf;
    assign o_udf    = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo_sc.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_fifo_sc
// Description : Self-checking bench for tx_fifo_sc (DEPTH = 8). A behavioural
//               model keeps expected words in a queue, and popped words are
//               compared against it. Flags, level and head word are checked
//               after every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_fifo_sc;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          push, wlast, wdrop, pop, clr_err;
    logic [DW-1:0] wdata;
    logic          full, rvalid, afull, aempty, ovf, udf;
    logic [DW-1:0] rdata;
    logic [AW:0]   level, afull_thr, aempty_thr;

    always #5 clk = ~clk;

    tx_fifo_sc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_push(push), .i_wdata(wdata),
        .i_wlast(wlast), .i_wdrop(wdrop), .o_full(full), .o_rvalid(rvalid),
        .o_rdata(rdata), .i_pop(pop), .o_level(level),
        .i_afull_thr(afull_thr), .i_aempty_thr(aempty_thr), .o_afull(afull),
        .o_aempty(aempty), .i_clr_err(clr_err), .o_ovf(ovf), .o_udf(udf)
    );

    int n_err = 0;
    int n_chk = 0;

    logic [DW-1:0] q[$];      // readable words, head first
    logic [DW-1:0] pend[$];   // uncommitted packet words
    int   m_lvl, m_tot;
    logic m_rv, m_ovf, m_udf;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend.delete();
        m_lvl = 0; m_tot = 0;
        m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".level"},  32'(level),  32'(m_lvl));
        check({tag, ".full"},   32'(full),   32'(m_tot == DEPTH));
        check({tag, ".rvalid"}, 32'(rvalid), 32'(m_rv));
        check({tag, ".ovf"},    32'(ovf),    32'(m_ovf));
        check({tag, ".udf"},    32'(udf),    32'(m_udf));
        check({tag, ".afull"},  32'(afull),  32'(m_tot >= int'(afull_thr)));
        check({tag, ".aempty"}, 32'(aempty), 32'(m_lvl <= int'(aempty_thr)));
        if (m_rv) check({tag, ".head"}, 32'(rdata), 32'(q[0]));
    endtask

    // One clock cycle: inputs applied at a falling edge, model stepped at
    // the rising edge, outputs checked at the next falling edge.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit pp,
                        input bit last, input bit drop, input bit clr, input string tag);
        bit full_pre, pop_acc, push_acc, nrv, ovf_ev, udf_ev;
        push = p; wdata = d; pop = pp; wlast = last; wdrop = drop; clr_err = clr;
        full_pre = (m_tot == DEPTH);
        pop_acc  = pp && m_rv;
        if (pop_acc) check({tag, ".pop"}, 32'(rdata), 32'(q.pop_front()));
        @(posedge clk);
        nrv    = (m_lvl - int'(pop_acc)) > 0;
        ovf_ev = p && full_pre;
        udf_ev = pp && !m_rv;
        if (pop_acc) begin m_lvl--; m_tot--; end
`ifdef TX_FIFO_PKT_MODE_EN
        push_acc = p && !full_pre && !drop;
        if (drop || (ovf_ev && pend.size() > 0)) begin
            m_tot -= pend.size();
            pend.delete();
        end
        if (push_acc) begin
            pend.push_back(d);
            m_tot++;
            if (last) begin
                m_lvl += pend.size();
                foreach (pend[i]) q.push_back(pend[i]);
                pend.delete();
            end
        end
`else
        push_acc = p && !full_pre;
        if (push_acc) begin q.push_back(d); m_lvl++; m_tot++; end
`endif
        m_rv  = nrv;
        m_ovf = ovf_ev || (m_ovf && !clr);
        m_udf = udf_ev || (m_udf && !clr);
        @(negedge clk);
        push = 0; pop = 0; wlast = 0; wdrop = 0; clr_err = 0;
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; push = 0; wdata = '0; wlast = 0; wdrop = 0; pop = 0; clr_err = 0;
        afull_thr = 4'd6; aempty_thr = 4'd2;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("rst");
        check("rst.rdata", 32'(rdata), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // FWFT latency and ordering
        step(1, 8'h11, 0, 0, 0, 0, "lat1");
        check("lat1.rv0", 32'(rvalid), 32'h0);
        step(1, 8'h22, 0, 0, 0, 0, "lat2");
        check("lat2.data", 32'(rdata), 32'h11);
        step(1, 8'h33, 0, 0, 0, 0, "lat3");
        check("lat3.level", 32'(level), 32'd3);
        repeat (3) step(0, 0, 1, 0, 0, 0, "drain1");

        // Fill to full, overflow, clear, push+pop while full
        for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom), 0, 0, 0, 0, "fill");
        check("fill.full", 32'(full), 32'h1);
        step(1, 8'hEE, 0, 0, 0, 0, "ovf");
        check("ovf.level", 32'(level), 32'd8);
        step(0, 0, 0, 0, 0, 1, "clr_ovf");
        check("clr_ovf.ovf", 32'(ovf), 32'h0);
        step(1, 8'hAB, 1, 0, 0, 0, "full_pp");
        step(0, 0, 0, 0, 0, 1, "clr2");

        // Streaming at half-full across pointer wrap
        repeat (3) step(0, 0, 1, 0, 0, 0, "drain2");
        for (int i = 0; i < 20; i++) step(1, DW'($urandom), 1, 0, 0, 0, "stream");
        check("stream.level", 32'(level), 32'd4);
        repeat (4) step(0, 0, 1, 0, 0, 0, "drain3");

        // Underflow; error wins over a simultaneous clear
        step(0, 0, 1, 0, 0, 0, "udf");
        check("udf.rv", 32'(rvalid), 32'h0);
        step(0, 0, 1, 0, 0, 1, "udf_clr");
        step(0, 0, 0, 0, 0, 1, "clr3");

        // Almost-empty (thr 2) and almost-full (thr 6)
        step(1, 8'h01, 0, 0, 0, 0, "ae1");
        step(1, 8'h02, 0, 0, 0, 0, "ae2");
        check("ae2.aempty", 32'(aempty), 32'h1);
        step(1, 8'h03, 0, 0, 0, 0, "ae3");
        check("ae3.aempty", 32'(aempty), 32'h0);
        step(1, 8'h04, 0, 0, 0, 0, "af4");
        step(1, 8'h05, 0, 0, 0, 0, "af5");
        check("af5.afull", 32'(afull), 32'h0);
        step(1, 8'h06, 0, 0, 0, 0, "af6");
        check("af6.afull", 32'(afull), 32'h1);

        // Asynchronous reset mid-stream
        push = 1; wdata = 8'h77; pop = 1;
        rst = 1'b1;
        #1;
        check("arst.rvalid", 32'(rvalid), 32'h0);
        check("arst.rdata",  32'(rdata),  32'h0);
        check("arst.level",  32'(level),  32'h0);
        check("arst.full",   32'(full),   32'h0);
        check("arst.ovf",    32'(ovf),    32'h0);
        check("arst.udf",    32'(udf),    32'h0);
        check("arst.aempty", 32'(aempty), 32'h1);
        check("arst.afull",  32'(afull),  32'h0);
        push = 0; pop = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("post_rst");

`ifdef TX_FIFO_PKT_MODE_EN
        // Words become readable only on the committing push
        step(1, 8'hA1, 0, 0, 0, 0, "pk1");
        step(1, 8'hA2, 0, 0, 0, 0, "pk2");
        step(1, 8'hA3, 0, 0, 0, 0, "pk3");
        check("pk3.rv", 32'(rvalid), 32'h0);
        step(1, 8'hA4, 0, 1, 0, 0, "pk4");
        step(0, 0, 0, 0, 0, 0, "pk5");
        check("pk5.rv", 32'(rvalid), 32'h1);
        // Dropped packet leaves the level alone and frees its space
        step(1, 8'hB1, 0, 0, 0, 0, "dr1");
        step(1, 8'hB2, 0, 0, 0, 0, "dr2");
        step(1, 8'hB3, 0, 0, 0, 0, "dr3");
        step(0, 0, 0, 0, 1, 0, "drop");
        check("drop.level", 32'(level), 32'd4);
        for (int i = 0; i < 4; i++) step(1, DW'(8'hC0 + i), 0, (i == 3), 0, 0, "refill");
        check("refill.full", 32'(full), 32'h1);
        repeat (8) step(0, 0, 1, 0, 0, 0, "pk_drain");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
